mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port to one-port memory arbiter between the pipelined core's instruction-fetch port and data load/store port and a single shared, variable-latency memory. It serialises requests with round-robin fairness and returns a per-port acknowledge and registered read data. It also drives a pipeline stall request and aborts transactions the memory never acknowledges. It sits between the core top level and the unified memory/bus.

## Interface

Parameters:
- XLEN, 32, address/data width.
- TIMEOUT, 64, max cycles a grant waits for m_ack before abort; 0 disables the timeout.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request, level; held with i_addr until i_ack.
- i_addr  in  XLEN  fetch address.
- i_ack  out  1  one-cycle completion pulse for fetch.
- i_rdata  out  XLEN  fetched word; registered, held until the next fetch completes.
- d_req  in  1  data request, level; held with d_we, d_addr, d_wdata until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  XLEN  data address.
- d_wdata  in  XLEN  store word (already byte-merged by the core).
- d_ack  out  1  one-cycle completion pulse for data.
- d_rdata  out  XLEN  load word; registered, held; unchanged by stores.
- err  out  1  one-cycle pulse, coincident with the i_ack/d_ack of a timed-out transaction.
- stall  out  1  combinational: (i_req & ~i_ack) | (d_req & ~d_ack).
- m_req  out  1  memory request; held high until m_ack or abort.
- m_we  out  1  memory write enable.
- m_addr  out  XLEN  memory address; registered, stable while m_req.
- m_wdata  out  XLEN  memory write data; registered, stable while m_req.
- m_ack  in  1  memory completion; m_rdata valid in the same cycle.
- m_rdata  in  XLEN  memory read data.

## Operation

- FSM states: IDLE, BUSY_I, BUSY_D. The `last` register records the last granted port (I or D).
- IDLE, one port requesting: that port is granted.
- IDLE, both ports requesting: the port not equal to `last` is granted.
- IDLE, no request: stay in IDLE; m_req = 0.
- On grant: latch address, we, and wdata into m_*. Set m_req = 1 (m_we = 0 for fetch). Update `last`. Clear the wait counter. Move to BUSY_I or BUSY_D.
- BUSY_x with m_ack = 1 at an edge, next cycle:
  - x_ack = 1 and m_req = 0; state returns to IDLE.
  - Loads and fetches capture m_rdata into x_rdata.
- BUSY_x without m_ack: the counter increments. When the counter reaches TIMEOUT−1 with no m_ack (TIMEOUT ≠ 0), abort:
  - m_req drops; x_ack = 1 and err = 1 next cycle.
  - x_rdata is set to 0 for a load or fetch.
- m_ack while in IDLE is ignored.
- Requester rules:
  - In its ack cycle a requester may hold req high with new address/data. This is sampled as a new request in IDLE at the end of that cycle.
  - Dropping req before ack is illegal and is not checked. The transaction completes regardless.
- Counter width: $clog2(TIMEOUT+1), minimum 1.

## Timing

- Reset (reset = 0, asynchronous):
  - State = IDLE, `last` = I, so D wins the first tie.
  - Counter = 0.
  - m_req, m_we, m_addr, m_wdata, i_ack, d_ack, i_rdata, d_rdata, err = 0.
- Reset mid-transaction abandons it: m_req drops immediately and no ack is issued.
- Latency: request high in cycle 0 → m_req high in cycle 1. If the memory acks in cycle k (k ≥ 1), x_ack is high in cycle k+1. The minimum is 2 cycles.
- Throughput: one access per 2 cycles from a single port. With both ports back-to-back, grants alternate I/D.
- Abort timing: m_req high for exactly TIMEOUT cycles. err/x_ack occurs at cycle TIMEOUT+1 after the grant edge.
- m_ack in the same cycle the counter hits TIMEOUT−1: treated as normal completion, err = 0.
- stall deasserts in the ack cycle so the core advances on that edge.

## Test plan

- Single fetch, memory acks 1 cycle after m_req, m_rdata = 0x00000013 → m_req high for 1 cycle, i_ack in cycle 2, i_rdata = 0x13, stall high in cycles 0–1.
- Both ports request from reset; d_we = 1, d_addr = 0x100, d_wdata = 0xDEADBEEF → D granted first (m_we = 1, m_addr = 0x100), then I. Then, with both held, grants alternate I, D, I.
- Load with a 5-cycle memory delay (m_rdata = 0xA5A5A5A5) → m_req/m_addr stable for 5 cycles, d_ack one cycle later, d_rdata = 0xA5A5A5A5, i_rdata unchanged.
- TIMEOUT = 4, memory never acks a fetch → m_req high 4 cycles, then i_ack = 1 and err = 1 together, i_rdata = 0, FSM back in IDLE. With TIMEOUT = 0, the same stimulus waits indefinitely.
- reset pulsed low while in BUSY_D → m_req = 0 asynchronously, no d_ack. After release, a pending d_req is granted afresh. A spurious m_ack in IDLE changes nothing.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the core's fetch/data ports, the arbiter and the shared memory.
// The master modport is the arbiter's view; slave is the environment (core plus memory).
interface mem_arbiter_if #(
    parameter int XLEN = 32
);
    logic            i_req;
    logic [XLEN-1:0] i_addr;
    logic            i_ack;
    logic [XLEN-1:0] i_rdata;
    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_ack;
    logic [XLEN-1:0] d_rdata;
    logic            err;
    logic            stall;
    logic            m_req;
    logic            m_we;
    logic [XLEN-1:0] m_addr;
    logic [XLEN-1:0] m_wdata;
    logic            m_ack;
    logic [XLEN-1:0] m_rdata;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, err, stall, m_req, m_we, m_addr, m_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, err, stall, m_req, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory between the fetch and data ports,
// with per-port ack, registered read data, pipeline stall and an abort on missing m_ack.
//
// state    | meaning
// S_IDLE   | no transaction in flight; grant on the next edge if a port requests
// S_BUSY_I | fetch owns the memory, waiting for m_ack or timeout
// S_BUSY_D | load/store owns the memory, waiting for m_ack or timeout
module mem_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.master bus
);
    localparam int            CW     = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int            TC_INT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CW-1:0] TC     = CW'(TC_INT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last_d;
    logic [CW-1:0]   r_cnt;
    logic            r_m_req;
    logic            r_m_we;
    logic [XLEN-1:0] r_m_addr;
    logic [XLEN-1:0] r_m_wdata;
    logic            r_i_ack;
    logic            r_d_ack;
    logic            r_err;
    logic [XLEN-1:0] r_i_rdata;
    logic [XLEN-1:0] r_d_rdata;
    logic            w_grant_i;
    logic            w_grant_d;
    logic            w_done;
    logic            w_abort;
    logic            w_tc;

    assign w_tc = (TIMEOUT != 0) && (r_cnt == TC);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // On a tie the port that did not win last time is served.
                if (bus.i_req && bus.d_req) begin
                    w_grant_i = r_last_d;
                    w_grant_d = ~r_last_d;
                end else begin
                    w_grant_i = bus.i_req;
                    w_grant_d = bus.d_req;
                end
                if (w_grant_i) begin
                    w_state_nxt = S_BUSY_I;
                end else if (w_grant_d) begin
                    w_state_nxt = S_BUSY_D;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                if (bus.m_ack) begin
                    w_done = 1'b1;
                end else if (w_tc) begin
                    w_abort = 1'b1;
                end
                if (w_done || w_abort) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_last_d  <= 1'b0;
            r_cnt     <= '0;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_err     <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            r_err   <= 1'b0;
            if (w_grant_i || w_grant_d) begin
                r_m_req   <= 1'b1;
                r_m_we    <= w_grant_d & bus.d_we;
                r_m_addr  <= w_grant_d ? bus.d_addr : bus.i_addr;
                r_m_wdata <= w_grant_d ? bus.d_wdata : '0;
                r_last_d  <= w_grant_d;
                r_cnt     <= '0;
            end else if (w_done || w_abort) begin
                r_m_req <= 1'b0;
                r_m_we  <= 1'b0;
                r_err   <= w_abort;
                if (r_state == S_BUSY_I) begin
                    r_i_ack   <= 1'b1;
                    r_i_rdata <= w_abort ? '0 : bus.m_rdata;
                end else begin
                    r_d_ack <= 1'b1;
                    // Stores leave the load data register untouched.
                    if (!r_m_we) begin
                        r_d_rdata <= w_abort ? '0 : bus.m_rdata;
                    end
                end
            end else if (r_state != S_IDLE && TIMEOUT != 0) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.m_req   = r_m_req;
    assign bus.m_we    = r_m_we;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_wdata = r_m_wdata;
    assign bus.i_ack   = r_i_ack;
    assign bus.d_ack   = r_d_ack;
    assign bus.err     = r_err;
    assign bus.i_rdata = r_i_rdata;
    assign bus.d_rdata = r_d_rdata;
    assign bus.stall   = (bus.i_req & ~r_i_ack) | (bus.d_req & ~r_d_ack);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (TIMEOUT 64, 4, 0) share one stimulus; a
// transaction-level model predicts grant order, ack timing, abort and read data.
module tb_mem_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ack = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;

    mem_arbiter_if #(.XLEN(32)) bus_a ();
    mem_arbiter_if #(.XLEN(32)) bus_b ();
    mem_arbiter_if #(.XLEN(32)) bus_c ();

    assign bus_a.i_req = i_req;  assign bus_a.i_addr = i_addr;  assign bus_a.d_req = d_req;
    assign bus_a.d_we = d_we;    assign bus_a.d_addr = d_addr;  assign bus_a.d_wdata = d_wdata;
    assign bus_a.m_ack = m_ack;  assign bus_a.m_rdata = m_rdata;
    assign bus_b.i_req = i_req;  assign bus_b.i_addr = i_addr;  assign bus_b.d_req = d_req;
    assign bus_b.d_we = d_we;    assign bus_b.d_addr = d_addr;  assign bus_b.d_wdata = d_wdata;
    assign bus_b.m_ack = m_ack;  assign bus_b.m_rdata = m_rdata;
    assign bus_c.i_req = i_req;  assign bus_c.i_addr = i_addr;  assign bus_c.d_req = d_req;
    assign bus_c.d_we = d_we;    assign bus_c.d_addr = d_addr;  assign bus_c.d_wdata = d_wdata;
    assign bus_c.m_ack = m_ack;  assign bus_c.m_rdata = m_rdata;

    mem_arbiter #(.XLEN(32), .TIMEOUT(64)) u_a (.clock(clock), .reset(reset), .bus(bus_a));
    mem_arbiter #(.XLEN(32), .TIMEOUT(4))  u_b (.clock(clock), .reset(reset), .bus(bus_b));
    mem_arbiter #(.XLEN(32), .TIMEOUT(0))  u_c (.clock(clock), .reset(reset), .bus(bus_c));

    int sel = 0;
    int tmo = 64;
    logic        ob_m_req, ob_m_we, ob_i_ack, ob_d_ack, ob_err, ob_stall;
    logic [31:0] ob_m_addr, ob_m_wdata, ob_i_rdata, ob_d_rdata;

    always_comb begin
        ob_m_req = bus_a.m_req;     ob_m_we = bus_a.m_we;       ob_m_addr = bus_a.m_addr;
        ob_m_wdata = bus_a.m_wdata; ob_i_ack = bus_a.i_ack;     ob_d_ack = bus_a.d_ack;
        ob_err = bus_a.err;         ob_stall = bus_a.stall;     ob_i_rdata = bus_a.i_rdata;
        ob_d_rdata = bus_a.d_rdata;
        if (sel == 1) begin
            ob_m_req = bus_b.m_req;     ob_m_we = bus_b.m_we;       ob_m_addr = bus_b.m_addr;
            ob_m_wdata = bus_b.m_wdata; ob_i_ack = bus_b.i_ack;     ob_d_ack = bus_b.d_ack;
            ob_err = bus_b.err;         ob_stall = bus_b.stall;     ob_i_rdata = bus_b.i_rdata;
            ob_d_rdata = bus_b.d_rdata;
        end
    end

    int n_pass = 0;
    int n_total = 0;

    // Reference model state: last granted port and the two read-data registers.
    bit          m_last_d = 1'b0;
    logic [31:0] m_i_rdata = '0;
    logic [31:0] m_d_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        i_req = 0; d_req = 0; d_we = 0; m_ack = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
        @(negedge clock); reset = 1'b0;
        @(negedge clock);
        @(negedge clock); reset = 1'b1;
        m_last_d = 1'b0; m_i_rdata = '0; m_d_rdata = '0;
    endtask

    // Called at the negedge of the cycle in which the request is sampled. lat = cycle (counted
    // from the first m_req cycle) in which the memory acks; 0 = never.
    task automatic do_txn(input bit exp_d, input int lat, input logic [31:0] rd);
        bit          aborted = 1'b0;
        bit          fin = 1'b0;
        int          c = 1;
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
        logic        exp_we;
        exp_addr = exp_d ? d_addr : i_addr;
        exp_wd   = d_wdata;
        exp_we   = exp_d & d_we;
        @(negedge clock);
        while (!fin) begin
            chk("m_req_busy", ob_m_req, 1);
            chk("m_addr", ob_m_addr, exp_addr);
            chk("m_we", ob_m_we, exp_we);
            if (exp_d) chk("m_wdata", ob_m_wdata, exp_wd);
            chk("stall_busy", ob_stall, 1);
            chk("ack_busy", {ob_i_ack, ob_d_ack, ob_err}, 0);
            if (c == lat) begin
                m_ack = 1'b1; m_rdata = rd; fin = 1'b1;
            end else if (tmo != 0 && c == tmo) begin
                aborted = 1'b1; fin = 1'b1;
            end else begin
                m_rdata = $urandom;
                @(negedge clock);
                c++;
            end
        end
        @(negedge clock);
        m_ack = 1'b0; m_rdata = $urandom;
        chk("i_ack", ob_i_ack, !exp_d);
        chk("d_ack", ob_d_ack, exp_d);
        chk("err", ob_err, aborted);
        chk("m_req_done", ob_m_req, 0);
        m_last_d = exp_d;
        if (!exp_d) m_i_rdata = aborted ? 32'h0 : rd;
        else if (!exp_we) m_d_rdata = aborted ? 32'h0 : rd;
        chk("i_rdata", ob_i_rdata, m_i_rdata);
        chk("d_rdata", ob_d_rdata, m_d_rdata);
        chk("stall_ack", ob_stall, (i_req & exp_d) | (d_req & ~exp_d));
    endtask

    task automatic rand_phase(input int n, input int maxlat);
        bit ed;
        for (int k = 0; k < n; k++) begin
            if (!i_req && $urandom_range(0, 2) != 0) begin
                i_req = 1'b1; i_addr = $urandom;
            end
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
            end
            if (!i_req && !d_req) begin
                m_ack = 1'b1; m_rdata = $urandom;
                @(negedge clock);
                m_ack = 1'b0;
                chk("idle_quiet", {ob_m_req, ob_i_ack, ob_d_ack, ob_err, ob_stall}, 0);
                chk("idle_i_rdata", ob_i_rdata, m_i_rdata);
                chk("idle_d_rdata", ob_d_rdata, m_d_rdata);
            end else begin
                ed = (i_req && d_req) ? !m_last_d : d_req;
                do_txn(ed, int'($urandom_range(1, maxlat)), $urandom);
                if (ed) d_req = 1'b0; else i_req = 1'b0;
            end
        end
    endtask

    initial begin
        sel = 0; tmo = 64;
        do_reset();
        chk("rst_m_req", ob_m_req, 0);     chk("rst_m_we", ob_m_we, 0);
        chk("rst_m_addr", ob_m_addr, 0);   chk("rst_m_wdata", ob_m_wdata, 0);
        chk("rst_i_ack", ob_i_ack, 0);     chk("rst_d_ack", ob_d_ack, 0);
        chk("rst_i_rdata", ob_i_rdata, 0); chk("rst_d_rdata", ob_d_rdata, 0);
        chk("rst_err", ob_err, 0);         chk("rst_stall", ob_stall, 0);

        // Single fetch, memory acks in the first m_req cycle.
        i_req = 1'b1; i_addr = 32'h40;
        #1;
        chk("fetch_stall_c0", ob_stall, 1);
        chk("fetch_m_req_c0", ob_m_req, 0);
        do_txn(1'b0, 1, 32'h0000_0013);
        i_req = 1'b0;

        // Both ports from reset: D first, then alternating.
        do_reset();
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        do_txn(1'b1, 1, $urandom);
        do_txn(1'b0, 1, 32'h1111_2222);
        do_txn(1'b1, 1, $urandom);
        do_txn(1'b0, 1, 32'h3333_4444);
        i_req = 1'b0; d_req = 1'b0;

        // Load with a 5-cycle memory delay.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        do_txn(1'b1, 5, 32'hA5A5_A5A5);
        d_req = 1'b0;

        // Reset while in BUSY_D; the still-held request is granted afresh afterwards.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        @(negedge clock);
        chk("busy_d_m_req", ob_m_req, 1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("async_rst_m_req", ob_m_req, 0);
        chk("async_rst_d_ack", ob_d_ack, 0);
        m_last_d = 1'b0; m_i_rdata = '0; m_d_rdata = '0;
        @(negedge clock);
        chk("rst_no_d_ack", ob_d_ack, 0);
        reset = 1'b1;
        do_txn(1'b1, 2, 32'h5A5A_0001);
        d_req = 1'b0;

        // Spurious m_ack in IDLE.
        m_ack = 1'b1; m_rdata = 32'hFFFF_0000;
        @(negedge clock);
        m_ack = 1'b0;
        chk("spur_acks", {ob_i_ack, ob_d_ack, ob_err, ob_m_req}, 0);
        chk("spur_d_rdata", ob_d_rdata, m_d_rdata);
        chk("spur_i_rdata", ob_i_rdata, m_i_rdata);

        // TIMEOUT = 4: ack exactly at the limit completes normally, no ack aborts.
        do_reset();
        sel = 1; tmo = 4;
        i_req = 1'b1; i_addr = 32'h80;
        do_txn(1'b0, 4, 32'h0000_1234);
        i_addr = 32'h84;
        do_txn(1'b0, 0, 32'h0);
        chk("t0_still_busy", bus_c.m_req, 1);
        chk("t0_no_ack", {bus_c.i_ack, bus_c.err}, 0);
        i_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            chk("t4_idle", {ob_m_req, ob_i_ack, ob_err}, 0);
            chk("t0_waiting", {bus_c.m_req, bus_c.i_ack}, 2'b10);
        end
        m_ack = 1'b1; m_rdata = 32'hCAFE_0001;
        @(negedge clock);
        m_ack = 1'b0;
        chk("t0_late_ack", bus_c.i_ack, 1);
        chk("t0_late_rdata", bus_c.i_rdata, 32'hCAFE_0001);
        chk("t0_late_err", bus_c.err, 0);
        chk("t4_ignore_ack", {ob_i_ack, ob_err, ob_m_req}, 0);
        chk("t4_ignore_rdata", ob_i_rdata, 0);

        // Randomized traffic against the model, short timeout then default.
        do_reset();
        sel = 1; tmo = 4;
        rand_phase(120, 6);
        do_reset();
        sel = 0; tmo = 64;
        rand_phase(150, 8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
